// File: rtl/pce_bram_ctrl.sv
// Backup-RAM transfer sequencer for the PC Engine core.
// Moves the save image between the HPS SD block interface and port B of the
// two byte-wide backup-RAM halves, one sector per sd_ack burst. It also writes
// the 4-word "HUBM" format header into the start of the RAM.
//
// Request handshake with the HPS: sd_rd/sd_wr is raised to ask for the sector
// at sd_lba and held until the HPS acknowledges with a rising sd_ack. The
// transfer runs while sd_ack is high. The falling sd_ack completes the sector,
// and the next request (or the return to idle) is visible one cycle later.
module pce_bram_ctrl #(
  parameter int SECTORS = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic        format,
  input  logic        downloading,
  input  logic        img_size_nz,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [11:0] bram_addr_b,
  output logic [15:0] bram_data_b,
  output logic        bram_we_b,
  output logic        bk_loading,
  output logic        bk_state,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SAVE   = 2'd2,
    S_FORMAT = 2'd3
  } state_t;

  localparam logic [3:0] LAST_LBA = 4'(SECTORS - 1);

  state_t      state_q;
  logic [3:0]  lba_q;
  logic        rd_q;
  logic        wr_q;
  logic        busy_q;
  logic        loading_q;
  logic [1:0]  fmt_idx_q;
  logic [15:0] fmt_data_q;

  logic bk_load_q;
  logic bk_save_q;
  logic format_q;
  logic downloading_q;
  logic sd_ack_q;

  // Header word i of the "HUBM" format block.
  function automatic logic [15:0] hdr_word(input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_word = 16'h5548;
      2'd1:    hdr_word = 16'h4D42;
      2'd2:    hdr_word = 16'h8800;
      default: hdr_word = 16'h8010;
    endcase
  endfunction

  // Previous-value registers keep tracking through reset, so a level that is
  // held high across reset release does not look like a new edge.
  always_ff @(posedge clk_sys) begin
    bk_load_q     <= bk_load;
    bk_save_q     <= bk_save;
    format_q      <= format;
    downloading_q <= downloading;
    sd_ack_q      <= sd_ack;
  end

  logic load_rise;
  logic save_rise;
  logic fmt_rise;
  logic dl_fall;
  logic ack_rise;
  logic ack_fall;

  assign load_rise = bk_load & ~bk_load_q;
  assign save_rise = bk_save & ~bk_save_q;
  assign fmt_rise  = format & ~format_q;
  assign dl_fall   = ~downloading & downloading_q;
  assign ack_rise  = sd_ack & ~sd_ack_q;
  assign ack_fall  = ~sd_ack & sd_ack_q;

  // Sequencer: trigger decode in idle, per-sector handshake, and the format burst.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lba_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      loading_q  <= 1'b0;
      fmt_idx_q  <= '0;
      fmt_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Load wins over save, and both win over format; losers are dropped.
          if (bk_ena && (load_rise || (dl_fall && img_size_nz))) begin
            state_q   <= S_LOAD;
            lba_q     <= '0;
            rd_q      <= 1'b1;
            busy_q    <= 1'b1;
            loading_q <= 1'b1;
          end else if (bk_ena && save_rise) begin
            state_q <= S_SAVE;
            lba_q   <= '0;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (fmt_rise) begin
            state_q    <= S_FORMAT;
            busy_q     <= 1'b1;
            fmt_idx_q  <= 2'd0;
            fmt_data_q <= hdr_word(2'd0);
          end
        end
        S_LOAD, S_SAVE: begin
          if (ack_rise) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
          end else if (ack_fall) begin
            if (lba_q == LAST_LBA) begin
              state_q   <= S_IDLE;
              lba_q     <= '0;
              busy_q    <= 1'b0;
              loading_q <= 1'b0;
            end else begin
              lba_q <= lba_q + 4'd1;
              rd_q  <= (state_q == S_LOAD);
              wr_q  <= (state_q == S_SAVE);
            end
          end
        end
        S_FORMAT: begin
          if (fmt_idx_q == 2'd3) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            fmt_idx_q  <= '0;
            fmt_data_q <= '0;
          end else begin
            fmt_idx_q  <= fmt_idx_q + 2'd1;
            fmt_data_q <= hdr_word(fmt_idx_q + 2'd1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // B-port mux: registered header words during format, otherwise straight
  // from the HPS buffer interface so no data pipelining is needed.
  always_comb begin
    bram_we_b   = 1'b0;
    bram_addr_b = {lba_q, sd_buff_addr};
    bram_data_b = sd_buff_dout;
    if (state_q == S_FORMAT) begin
      bram_we_b   = 1'b1;
      bram_addr_b = {10'd0, fmt_idx_q};
      bram_data_b = fmt_data_q;
    end else if (state_q == S_LOAD) begin
      bram_we_b = sd_buff_wr & sd_ack;
    end
  end

  assign sd_lba     = {28'd0, lba_q};
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign bk_loading = loading_q;
  assign bk_state   = busy_q;
  assign dbg_state  = state_q;

endmodule
